test_monitor: RTL and testbench
===============================

Name: test_monitor

Overview:
Synthesizable run monitor for the RISC-V core. It observes the core's gp, a7 and a0 register taps and its memory write port, and detects riscv-tests completion by either the exit-ecall convention or a tohost store. It reports pass, fail or timeout, the last test number, cycle count and cumulative pass/fail counters. The same block sits beside `processor` in simulation and on FPGA, replacing bench-side polling.

Parameters:
WIDTH, 32, data/address width of the taps
MODE, 2, 0 = register convention only, 1 = tohost store only, 2 = both
TOHOST_ADDR, 32'h0000_1000, byte address of the tohost word
TIMEOUT_CYCLES, 3000, number of RUNNING cycles before timeout; must be ≥1
CNT_WIDTH, 16, width of pass_count and fail_count
HANG_CYCLES, 64, consecutive cycles with an unchanged pc that count as a hang (used only with the macro)

Ports:
clock  in  1  system clock; all state changes on its rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse that begins a run
gp  in  WIDTH  x3 tap
a7  in  WIDTH  x17 tap
a0  in  WIDTH  x10 tap; ignored by this block, kept for debug probing
pc  in  WIDTH  core PC; used only when TEST_MON_HANG_DETECT_EN is defined
memEn  in  1  store strobe from the core
memAddr  in  WIDTH  store address
memData  in  WIDTH  store data
busy  out  1  high while in RUNNING
done  out  1  high while in DONE
status  out  2  result code, enum status_t: NONE=0, PASS=1, FAIL=2, TIMEOUT=3
test_no  out  WIDTH  last passed test (on PASS) or failing test (on FAIL/TIMEOUT)
cycle_count  out  32  RUNNING cycles elapsed, saturating
pass_count  out  CNT_WIDTH  runs passed since reset, saturating
fail_count  out  CNT_WIDTH  runs failed or timed out since reset, saturating

Behaviour:
- Reset: state=IDLE. busy=0, done=0, status=NONE, test_no=1, cycle_count=0, pass_count=0, fail_count=0. All outputs are registered.
- Reset while in any state, including mid-run, discards the run and returns to the reset values. The counters clear too.
- FSM states: IDLE, RUNNING, DONE.
  - IDLE or DONE with start=1 → RUNNING. On that edge: cycle_count=0, test_no=1, status=NONE.
  - start while RUNNING is ignored.
- RUNNING, evaluated every edge:
  - cycle_count increments, saturating at 2^32-1.
  - If gp≥2 (unsigned), test_no ← gp. This tracks progress.
- Termination events, evaluated on the sampled inputs:
  - REG event (MODE 0 or 2): a7==ECALL_EXIT (93). Result is PASS if gp==1; otherwise FAIL with test_no ← gp>>1.
  - TOHOST event (MODE 1 or 2): memEn && memAddr==TOHOST_ADDR && memData[0]==1. Result is PASS if memData==1; otherwise FAIL with test_no ← memData>>1.
  - A tohost store with memData[0]==0 is ignored.
  - If both events fire in the same cycle, TOHOST takes precedence.
- Timeout: when cycle_count==TIMEOUT_CYCLES-1 and no termination event occurs that cycle → TIMEOUT, with test_no ← gp>>1. A termination event in the same cycle wins over the timeout.
- On any termination: state→DONE on that same edge. done and status are visible the following cycle, i.e. 1-cycle latency.
  - pass_count increments on PASS.
  - fail_count increments on FAIL or TIMEOUT.
  - Both counters saturate at all-ones.
- DONE: holds status, test_no and cycle_count until the next start or reset. Inputs are ignored.
- The PASS test_no is the last gp≥2 seen before the terminating cycle; it is not updated on the terminating cycle itself.

Optional Feature:
TEST_MON_HANG_DETECT_EN
- Defined: a hang counter runs in RUNNING.
  - It resets to 0 when pc differs from its previously registered value, and increments when pc is unchanged.
  - When it reaches HANG_CYCLES-1 with no termination event → TIMEOUT early, test_no ← gp>>1.
  - The hang counter clears on start and on reset.
- Undefined: no pc register or hang counter is instantiated. The pc port is unused, and the only timeout is TIMEOUT_CYCLES.

Decomposition:
- Package test_monitor_pkg holds:
  - state_t {IDLE, RUNNING, DONE}
  - status_t {NONE, PASS, FAIL, TIMEOUT}
  - localparam ECALL_EXIT=93
  - MODE_REG=0, MODE_TOHOST=1, MODE_BOTH=2
- One sub-module: sat_counter (parameter W, inputs clr and inc, output value). It is instantiated for cycle_count, pass_count, fail_count and the hang counter.

Test Plan:
1. REG pass: start; drive gp=2, 3, 4 on successive cycles, then gp=1 with a7=93 → next cycle done=1, status=PASS, test_no=4, pass_count=1.
2. REG fail: gp=5 held, then a7=93 with gp=11 → status=FAIL, test_no=5, fail_count=1.
3. TOHOST, MODE=1: store memAddr=0x1000, memData=0x0000_000D → FAIL, test_no=6. A store with memData=0x2 is ignored. A store with memData=1 on a fresh run → PASS. With a7=93 and MODE=1 there is no termination.
4. Timeout with TIMEOUT_CYCLES=10: no events, gp=7 → done exactly 10 cycles after start is accepted, status=TIMEOUT, test_no=3. Repeat with a7=93 asserted on cycle 9 → PASS or FAIL, not TIMEOUT.
5. Reset mid-run: reset on cycle 4 of RUNNING → next cycle busy=0, status=NONE, counters=0. Back-to-back start in DONE restarts with cycle_count=0. start during RUNNING has no effect.
6. TEST_MON_HANG_DETECT_EN with HANG_CYCLES=4: hold pc=0x80 → TIMEOUT after 4 cycles. Toggling pc every 3 cycles produces no timeout before TIMEOUT_CYCLES.

Source files
------------

// File: rtl/test_monitor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : test_monitor_pkg                                               |
// | Brief   : Shared types and constants for the riscv-tests run monitor.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package test_monitor_pkg;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t RUNNING = 2'd1;
  localparam state_t DONE    = 2'd2;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } status_t;

  localparam int ECALL_EXIT  = 93;

  localparam int MODE_REG    = 0;
  localparam int MODE_TOHOST = 1;
  localparam int MODE_BOTH   = 2;

  function automatic logic mode_has_reg(input int mode);
    return (mode == MODE_REG) || (mode == MODE_BOTH);
  endfunction

  function automatic logic mode_has_tohost(input int mode);
    return (mode == MODE_TOHOST) || (mode == MODE_BOTH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/test_monitor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : test_monitor_if                                                |
// | Brief   : Core register taps and store port observed by the run monitor. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface test_monitor_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] gp;
  logic [WIDTH-1:0] a7;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] pc;
  logic             memEn;
  logic [WIDTH-1:0] memAddr;
  logic [WIDTH-1:0] memData;

  modport master (
    output gp, a7, a0, pc, memEn, memAddr, memData
  );

  modport slave (
    input gp, a7, a0, pc, memEn, memAddr, memData
  );
endinterface
`default_nettype wire

// File: rtl/test_monitor_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sat_counter                                                    |
// | Brief   : Up-counter with synchronous clear that sticks at all-ones.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/test_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : test_monitor                                                   |
// | Brief   : riscv-tests run monitor: ecall-exit / tohost completion,       |
// |           timeout, result code and pass/fail tallies.                    |
// |           Optional macro TEST_MON_HANG_DETECT_EN adds a stuck-pc timeout.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter int               MODE           = MODE_BOTH,
  parameter logic [WIDTH-1:0] TOHOST_ADDR    = 'h0000_1000,
  parameter int               TIMEOUT_CYCLES = 3000,
  parameter int               CNT_WIDTH      = 16,
  parameter int               HANG_CYCLES    = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  test_monitor_if.slave        tap,
  output logic                 busy,
  output logic                 done,
  output status_t              status,
  output logic [WIDTH-1:0]     test_no,
  output logic [31:0]          cycle_count,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] fail_count
);

  state_t           r_state;
  logic             w_running;
  logic             w_start_acc;
  logic             w_reg_ev;
  logic             w_th_ev;
  logic             w_cyc_to;
  logic             w_hang_to;
  logic             w_term;
  status_t          w_result;
  logic [WIDTH-1:0] w_fail_no;
  logic             w_pass_inc;
  logic             w_fail_inc;
  logic             w_unused;

  assign w_running   = (r_state == RUNNING);
  assign w_start_acc = (r_state != RUNNING) && start;

  assign w_reg_ev = mode_has_reg(MODE) && (tap.a7 == WIDTH'(ECALL_EXIT));
  // Only odd tohost values terminate; even stores are console/syscall traffic.
  assign w_th_ev  = mode_has_tohost(MODE) && tap.memEn &&
                    (tap.memAddr == TOHOST_ADDR) && tap.memData[0];
  assign w_cyc_to = (cycle_count == 32'(TIMEOUT_CYCLES - 1));

`ifdef TEST_MON_HANG_DETECT_EN
  localparam int HANG_W = (HANG_CYCLES > 1) ? $clog2(HANG_CYCLES) : 1;

  logic [WIDTH-1:0]  r_pc;
  logic [HANG_W-1:0] w_hang_count;
  logic              w_pc_same;

  always_ff @(posedge clock) begin
    r_pc <= tap.pc;
  end

  assign w_pc_same = (tap.pc == r_pc);
  assign w_hang_to = (w_hang_count == HANG_W'(HANG_CYCLES - 1));

  sat_counter #(.W(HANG_W)) u_hang_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (w_start_acc || (w_running && !w_pc_same)),
    .inc   (w_running && w_pc_same),
    .value (w_hang_count)
  );

  assign w_unused = ^tap.a0;
`else
  assign w_hang_to = 1'b0;
  assign w_unused  = ^{tap.a0, tap.pc};
`endif

  assign w_term = w_running && (w_th_ev || w_reg_ev || w_cyc_to || w_hang_to);

  // Priority: tohost store, then ecall exit, then either timeout.
  always_comb begin
    w_result  = TIMEOUT;
    w_fail_no = tap.gp >> 1;
    if (w_th_ev) begin
      w_result  = (tap.memData == WIDTH'(1)) ? PASS : FAIL;
      w_fail_no = tap.memData >> 1;
    end else if (w_reg_ev) begin
      w_result  = (tap.gp == WIDTH'(1)) ? PASS : FAIL;
      w_fail_no = tap.gp >> 1;
    end
  end

  assign w_pass_inc = w_term && (w_result == PASS);
  assign w_fail_inc = w_term && (w_result != PASS);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      status  <= NONE;
      test_no <= WIDTH'(1);
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= RUNNING;
            busy    <= 1'b1;
            done    <= 1'b0;
            status  <= NONE;
            test_no <= WIDTH'(1);
          end
        end
        RUNNING: begin
          if (w_term) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            status  <= w_result;
            // A pass keeps the last progress marker seen before this cycle.
            if (w_result != PASS) begin
              test_no <= w_fail_no;
            end
          end else if (tap.gp >= WIDTH'(2)) begin
            test_no <= tap.gp;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          status  <= NONE;
          test_no <= WIDTH'(1);
        end
      endcase
    end
  end

  sat_counter #(.W(32)) u_cycle_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (w_start_acc),
    .inc   (w_running),
    .value (cycle_count)
  );

  sat_counter #(.W(CNT_WIDTH)) u_pass_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (1'b0),
    .inc   (w_pass_inc),
    .value (pass_count)
  );

  sat_counter #(.W(CNT_WIDTH)) u_fail_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (1'b0),
    .inc   (w_fail_inc),
    .value (fail_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_test_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_test_monitor                                                |
// | Brief   : Two monitors (MODE 2 and MODE 1) on shared taps, checked every |
// |           cycle against a run-level model plus directed literal checks.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_test_monitor;

  localparam int          TO_CYC = 10;
  localparam int          HANG   = 4;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy0, done0, busy1, done1;
  logic [1:0]  status0, status1;
  logic [31:0] test_no0, test_no1, cyc0, cyc1;
  logic [15:0] pass0, fail0, pass1, fail1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  bit pc_walk = 1;
  int n;
  logic [31:0] prev_pc;

  test_monitor_if #(.WIDTH(32)) tap ();

  always #5 clock = ~clock;

  test_monitor #(.WIDTH(32), .MODE(2), .TOHOST_ADDR(TOHOST), .TIMEOUT_CYCLES(TO_CYC),
                 .CNT_WIDTH(16), .HANG_CYCLES(HANG)) u_dut (
    .clock(clock), .reset(reset), .start(start), .tap(tap),
    .busy(busy0), .done(done0), .status(status0), .test_no(test_no0),
    .cycle_count(cyc0), .pass_count(pass0), .fail_count(fail0)
  );

  test_monitor #(.WIDTH(32), .MODE(1), .TOHOST_ADDR(TOHOST), .TIMEOUT_CYCLES(TO_CYC),
                 .CNT_WIDTH(16), .HANG_CYCLES(HANG)) u_dut_th (
    .clock(clock), .reset(reset), .start(start), .tap(tap),
    .busy(busy1), .done(done1), .status(status1), .test_no(test_no1),
    .cycle_count(cyc1), .pass_count(pass1), .fail_count(fail1)
  );

  // Run-level model: one record per monitor, advanced once per clock edge.
  typedef struct packed {
    logic        run;
    logic        dn;
    logic [1:0]  st;
    logic [31:0] tno;
    logic [31:0] cyc;
    logic [15:0] pcn;
    logic [15:0] fcn;
    logic [31:0] hang;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_next(input mdl_t m, input int mode, input logic rst,
                                    input logic stt, input logic [31:0] gp, a7,
                                    input logic men, input logic [31:0] maddr, mdata,
                                    input logic [31:0] pc, ppc);
    mdl_t n;
    logic reg_ev, th_ev, to;
    int res;
    logic [31:0] fno;
    n = m;
    if (rst) begin
      n.run = 0; n.dn = 0; n.st = 0; n.tno = 1; n.cyc = 0;
      n.pcn = 0; n.fcn = 0; n.hang = 0;
      return n;
    end
    if (!m.run) begin
      if (stt) begin
        n.run = 1; n.dn = 0; n.st = 0; n.tno = 1; n.cyc = 0; n.hang = 0;
      end
      return n;
    end
    reg_ev = (mode != 1) && (a7 == 32'd93);
    th_ev  = (mode != 0) && men && (maddr == TOHOST) && mdata[0];
    to     = (m.cyc == 32'(TO_CYC - 1));
`ifdef TEST_MON_HANG_DETECT_EN
    to     = to || (m.hang == 32'(HANG - 1));
    n.hang = (pc == ppc) ? m.hang + 1 : 0;
`endif
    if (m.cyc != 32'hFFFF_FFFF) n.cyc = m.cyc + 1;
    res = 0;
    fno = 0;
    if (th_ev) begin
      res = (mdata == 1) ? 1 : 2; fno = mdata >> 1;
    end else if (reg_ev) begin
      res = (gp == 1) ? 1 : 2; fno = gp >> 1;
    end else if (to) begin
      res = 3; fno = gp >> 1;
    end else if (gp >= 2) begin
      n.tno = gp;
    end
    if (res != 0) begin
      n.run = 0; n.dn = 1; n.st = 2'(res);
      if (res != 1) n.tno = fno;
      if (res == 1) begin
        if (n.pcn != 16'hFFFF) n.pcn = n.pcn + 1;
      end else begin
        if (n.fcn != 16'hFFFF) n.fcn = n.fcn + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clock) begin
    m0 = mdl_next(m0, 2, reset, start, tap.gp, tap.a7, tap.memEn, tap.memAddr,
                  tap.memData, tap.pc, prev_pc);
    m1 = mdl_next(m1, 1, reset, start, tap.gp, tap.a7, tap.memEn, tap.memAddr,
                  tap.memData, tap.pc, prev_pc);
    prev_pc = tap.pc;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy0", 64'(busy0), 64'(m0.run));
      chk("done0", 64'(done0), 64'(m0.dn));
      chk("status0", 64'(status0), 64'(m0.st));
      chk("test_no0", 64'(test_no0), 64'(m0.tno));
      chk("cycle0", 64'(cyc0), 64'(m0.cyc));
      chk("pass0", 64'(pass0), 64'(m0.pcn));
      chk("fail0", 64'(fail0), 64'(m0.fcn));
      chk("busy1", 64'(busy1), 64'(m1.run));
      chk("done1", 64'(done1), 64'(m1.dn));
      chk("status1", 64'(status1), 64'(m1.st));
      chk("test_no1", 64'(test_no1), 64'(m1.tno));
      chk("cycle1", 64'(cyc1), 64'(m1.cyc));
      chk("pass1", 64'(pass1), 64'(m1.pcn));
      chk("fail1", 64'(fail1), 64'(m1.fcn));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (pc_walk) tap.pc = tap.pc + 32'd4;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input bit which, input int lim, output int cnt);
    cnt = 0;
    while (((which ? done1 : done0) !== 1'b1) && (cnt < lim)) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0;
    tap.gp = 0; tap.a7 = 0; tap.a0 = 0; tap.pc = 32'h100;
    tap.memEn = 0; tap.memAddr = 0; tap.memData = 0;
    tick();
    chk_en = 1;
    tick();
    chk("rst busy", 64'(busy0), 64'd0);
    chk("rst status", 64'(status0), 64'd0);
    chk("rst test_no", 64'(test_no0), 64'd1);
    chk("rst counts", 64'({pass0, fail0, cyc0}), 64'd0);
    reset = 1'b0;
    tick();

    // Ecall-exit pass with progress markers 2,3,4.
    pulse_start();
    tap.gp = 2; tick();
    tap.gp = 3; tick();
    tap.gp = 4; tick();
    tap.gp = 1; tap.a7 = 93; tick();
    chk("reg pass done", 64'(done0), 64'd1);
    chk("reg pass status", 64'(status0), 64'd1);
    chk("reg pass test_no", 64'(test_no0), 64'd4);
    chk("reg pass count", 64'(pass0), 64'd1);
    chk("reg pass cycles", 64'(cyc0), 64'd4);
    chk("mode1 ignores ecall", 64'(busy1), 64'd1);
    tap.a7 = 0; tap.gp = 0;

    // Ecall-exit fail.
    pulse_start();
    tap.gp = 5; tick(); tick();
    tap.gp = 11; tap.a7 = 93; tick();
    chk("reg fail status", 64'(status0), 64'd2);
    chk("reg fail test_no", 64'(test_no0), 64'd5);
    chk("reg fail count", 64'(fail0), 64'd1);
    tap.a7 = 0; tap.gp = 0;
    run_until_done(1, 20, n);
    chk("mode1 timeout done", 64'(done1), 64'd1);
    chk("mode1 timeout status", 64'(status1), 64'd3);

    // Tohost stores.
    pulse_start();
    tap.memEn = 1; tap.memAddr = TOHOST; tap.memData = 32'h2; tick();
    chk("even tohost ignored", 64'({busy0, busy1}), 64'h3);
    tap.memData = 32'hD; tick();
    chk("tohost fail status", 64'(status1), 64'd2);
    chk("tohost fail test_no", 64'(test_no1), 64'd6);
    chk("tohost fail mode2", 64'({status0, test_no0}), {30'd0, 2'd2, 32'd6});
    tap.memEn = 0;
    pulse_start();
    tap.memEn = 1; tap.memData = 32'h1; tick();
    chk("tohost pass", 64'({status1, status0}), 64'h5);
    tap.memEn = 0;
    pulse_start();
    tap.gp = 1; tap.a7 = 93; tap.memEn = 1; tap.memData = 32'hD; tick();
    chk("tohost precedence", 64'({status0, test_no0}), {30'd0, 2'd2, 32'd6});
    chk("counts mode2", 64'({pass0, fail0}), 64'h0002_0003);
    tap.memEn = 0; tap.a7 = 0;

    // Cycle-budget timeout and event-beats-timeout.
    tap.gp = 7;
    pulse_start();
    run_until_done(0, 20, n);
    chk("timeout latency", 64'(n), 64'd10);
    chk("timeout status", 64'(status0), 64'd3);
    chk("timeout test_no", 64'(test_no0), 64'd3);
    pulse_start();
    repeat (9) tick();
    tap.a7 = 93; tick();
    chk("event wins timeout", 64'({done0, status0}), 64'h6);
    chk("mode1 still times out", 64'(status1), 64'd3);
    tap.a7 = 0;

    // Reset mid-run, restart from DONE, start ignored while running.
    pulse_start();
    repeat (4) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrun reset", 64'({busy0, done0, status0}), 64'd0);
    chk("midrun reset counts", 64'({pass0, fail0, cyc0}), 64'd0);
    chk("midrun reset test_no", 64'(test_no0), 64'd1);
    pulse_start();
    run_until_done(0, 20, n);
    chk("run2 timeout", 64'(n), 64'd10);
    pulse_start();
    chk("restart cycle", 64'({busy0, done0, cyc0}), {30'd0, 2'b10, 32'd0});
    repeat (3) tick();
    pulse_start();
    chk("start ignored running", 64'(cyc0), 64'd4);
    run_until_done(0, 20, n);
    chk("cleanup done", 64'(done0), 64'd1);

`ifdef TEST_MON_HANG_DETECT_EN
    pc_walk = 0;
    tap.pc = 32'h80;
    pulse_start();
    run_until_done(0, 20, n);
    chk("hang latency", 64'(n), 64'd4);
    chk("hang status", 64'(status0), 64'd3);
    tap.pc = 32'h100;
    pulse_start();
    n = 0;
    while ((done0 !== 1'b1) && (n < 20)) begin
      n++;
      if ((n % 3) == 0) tap.pc = tap.pc + 32'd4;
      tick();
    end
    chk("no hang on toggling pc", 64'(n), 64'd10);
`endif

    // Randomised traffic against the model.
    pc_walk = 0;
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 5) == 0);
      tap.gp      = 32'($urandom_range(0, 12));
      tap.a7      = ($urandom_range(0, 9) == 0) ? 32'd93 : 32'($urandom_range(80, 100));
      tap.a0      = $urandom;
      tap.memEn   = ($urandom_range(0, 3) == 0);
      tap.memAddr = ($urandom_range(0, 1) == 0) ? TOHOST : 32'h1004;
      tap.memData = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 2) != 0) tap.pc = tap.pc + 32'd4;
      tick();
    end
    reset = 1'b0; start = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
